// File: rtl/eth_tx_ctrl.sv
// rtl/eth_tx_ctrl.sv - RMII transmit framer: preamble/SFD, zero padding, CRC-32 FCS, inter-packet gap
module eth_tx_ctrl #(
   parameter int pPREAMBLE_BYTES  = 7,
   parameter int pMIN_FRAME_BYTES = 60,
   parameter int pIPG_BYTES       = 12
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       S_Valid,
   input  logic [7:0] S_Data,
   input  logic       S_Last,
   output logic       S_Ready,
   output logic [1:0] Txd,
   output logic       Tx_En,
   output logic       Busy,
   output logic       Frame_Done,
   output logic       Underrun
);
   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG} state_t;

   localparam logic [15:0] cPreLast  = 16'(pPREAMBLE_BYTES * 4 - 1);
   localparam logic [15:0] cIpgLast  = 16'(pIPG_BYTES * 4 - 1);
   localparam logic [15:0] cMinBytes = 16'(pMIN_FRAME_BYTES);

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] byteCnt;
   logic [31:0] crc;
   logic [31:0] sh;
   logic        curLast;
   logic        fetch;
   logic        byteEnd;

   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // fetch: last dibit of SFD or of a non-final data byte, where the next byte is due
   assign fetch   = (cnt == 16'd3) && ((state == SFD) || (state == DATA && !curLast));
   assign byteEnd = (cnt == 16'd3) && ((state == DATA && curLast) || state == PAD);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         cnt        <= '0;
         byteCnt    <= '0;
         crc        <= '1;
         sh         <= '0;
         curLast    <= 1'b0;
         Txd        <= 2'b00;
         Tx_En      <= 1'b0;
         S_Ready    <= 1'b0;
         Busy       <= 1'b0;
         Frame_Done <= 1'b0;
         Underrun   <= 1'b0;
      end else begin
         S_Ready    <= 1'b0;
         Frame_Done <= 1'b0;
         Underrun   <= 1'b0;
         cnt        <= cnt + 16'd1;
         Txd        <= sh[1:0];
         sh         <= sh >> 2;

         case (state)
            IDLE: begin
               cnt <= '0;
               Txd <= 2'b00;
               if (S_Valid) begin
                  state   <= PREAMBLE;
                  Tx_En   <= 1'b1;
                  Busy    <= 1'b1;
                  Txd     <= 2'b01;
                  crc     <= '1;
                  byteCnt <= '0;
               end
            end
            PREAMBLE: begin
               Txd <= 2'b01;
               if (cnt == cPreLast) begin
                  state <= SFD;
                  cnt   <= '0;
               end
            end
            SFD: begin
               Txd     <= (cnt == 16'd2) ? 2'b11 : 2'b01;
               S_Ready <= (cnt == 16'd2);
            end
            DATA: S_Ready <= (cnt == 16'd2) && !curLast;
            PAD: ;
            FCS: begin
               Frame_Done <= (cnt == 16'd14);
               if (cnt == 16'd15) begin
                  state <= IPG;
                  cnt   <= '0;
                  Tx_En <= 1'b0;
                  Txd   <= 2'b00;
               end
            end
            IPG: begin
               Txd <= 2'b00;
               if (cnt == cIpgLast) begin
                  state <= IDLE;
                  cnt   <= '0;
                  Busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (fetch) begin
            cnt <= '0;
            if (S_Valid) begin
               state   <= DATA;
               Txd     <= S_Data[1:0];
               sh      <= {24'd0, S_Data} >> 2;
               curLast <= S_Last;
               crc     <= crcByte(crc, S_Data);
               byteCnt <= (byteCnt == 16'hFFFF) ? byteCnt : byteCnt + 16'd1;
            end else begin
               state    <= IPG;
               Tx_En    <= 1'b0;
               Txd      <= 2'b00;
               Underrun <= 1'b1;
            end
         end

         // the saturated counter can never be below the minimum, so padding stops there
         if (byteEnd) begin
            cnt <= '0;
            if (byteCnt < cMinBytes) begin
               state   <= PAD;
               Txd     <= 2'b00;
               sh      <= '0;
               crc     <= crcByte(crc, 8'h00);
               byteCnt <= byteCnt + 16'd1;
            end else begin
               state <= FCS;
               Txd   <= ~crc[1:0];
               sh    <= (~crc) >> 2;
            end
         end
      end
   end
endmodule
